// File: rtl/pipe_rate_change_ctrl.sv
// pipe_rate_change_ctrl: MAC-side PIPE rate-change sequencer.
// Runs the PCLK-as-PHY-input handshake for LTSSM speed-change requests.
//
// Ports:
//   CLK, reset        clock, async active-high reset
//   ChangeReq         LTSSM request (accepted only in idle)
//   TargetRate[3:0]   requested rate, 0=Gen1 .. 4=Gen5
//   ActiveLanes[N]    lanes whose PhyStatus must be collected
//   PclkChangeOk      PHY ready for the PCLK change
//   PhyStatus[N]      per-lane PHY completion pulse
//   Rate[3:0]         PIPE Rate
//   PCLKRate[4:0]     PIPE PCLKRate (zero-extended Rate)
//   PclkChangeAck     MAC has switched PCLK
//   TxElecIdle[N]     all-ones while a change is in flight
//   Busy              sequence in progress
//   ChangeDone        one-cycle completion pulse
//   ChangeTimeout     one-cycle failure pulse

module pipe_rate_change_ctrl #(
  parameter int LANESNUMBER    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   ChangeReq,
  input  logic [3:0]             TargetRate,
  input  logic [LANESNUMBER-1:0] ActiveLanes,
  input  logic                   PclkChangeOk,
  input  logic [LANESNUMBER-1:0] PhyStatus,
  output logic [3:0]             Rate,
  output logic [4:0]             PCLKRate,
  output logic                   PclkChangeAck,
  output logic [LANESNUMBER-1:0] TxElecIdle,
  output logic                   Busy,
  output logic                   ChangeDone,
  output logic                   ChangeTimeout
);

  // Counter runs one past TIMEOUT_CYCLES-1 so the failure pulse
  // lands the cycle after the last allowed handshake cycle.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CntEnd = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    Idle,
    Req,
    Ack,
    Done
  } state_t;

  state_t                 state;
  logic [3:0]             prevRate;
  logic [LANESNUMBER-1:0] lanesQ;
  logic [LANESNUMBER-1:0] sticky;
  logic [CW-1:0]          cnt;

  logic allSeen;
  logic expired;
  logic rateOk;

  assign allSeen = ((sticky | PhyStatus) & lanesQ) == lanesQ;
  assign expired = cnt == CntEnd;
  assign rateOk  = TargetRate <= 4'd4;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state         <= Idle;
      Rate          <= '0;
      PCLKRate      <= '0;
      PclkChangeAck <= 1'b0;
      TxElecIdle    <= '1;
      Busy          <= 1'b0;
      ChangeDone    <= 1'b0;
      ChangeTimeout <= 1'b0;
      prevRate      <= '0;
      lanesQ        <= '0;
      sticky        <= '0;
      cnt           <= '0;
    end else begin
      ChangeDone    <= 1'b0;
      ChangeTimeout <= 1'b0;
      unique case (state)
        Idle: begin
          TxElecIdle <= '0;
          // Requests are held off while the timeout pulse is visible.
          if (ChangeReq && rateOk && !ChangeTimeout) begin
            if (TargetRate == Rate) begin
              state      <= Done;
              ChangeDone <= 1'b1;
            end else begin
              prevRate   <= Rate;
              lanesQ     <= ActiveLanes;
              Rate       <= TargetRate;
              PCLKRate   <= {1'b0, TargetRate};
              Busy       <= 1'b1;
              TxElecIdle <= '1;
              cnt        <= '0;
              state      <= Req;
            end
          end
        end
        Req: begin
          if (PclkChangeOk) begin
            state         <= Ack;
            PclkChangeAck <= 1'b1;
            cnt           <= expired ? cnt : cnt + 1'b1;
          end else if (expired) begin
            state         <= Idle;
            ChangeTimeout <= 1'b1;
            Rate          <= prevRate;
            PCLKRate      <= {1'b0, prevRate};
            PclkChangeAck <= 1'b0;
            Busy          <= 1'b0;
            TxElecIdle    <= '0;
            sticky        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        Ack: begin
          sticky <= sticky | PhyStatus;
          if (allSeen) begin
            state         <= Done;
            PclkChangeAck <= 1'b0;
            ChangeDone    <= 1'b1;
            Busy          <= 1'b0;
            TxElecIdle    <= '0;
          end else if (expired) begin
            state         <= Idle;
            ChangeTimeout <= 1'b1;
            Rate          <= prevRate;
            PCLKRate      <= {1'b0, prevRate};
            PclkChangeAck <= 1'b0;
            Busy          <= 1'b0;
            TxElecIdle    <= '0;
            sticky        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        Done: begin
          sticky <= '0;
          state  <= Idle;
        end
      endcase
    end
  end

endmodule
